// File: rtl/sfp_tx_arbiter.sv
// sfp_tx_arbiter: three-way arbiter (cmd > round-robin peer/local) onto one SFP TX stream
module sfp_tx_arbiter #(
    parameter int GAP_CYC = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_channel_up,
    input  logic [7:0]  i_burst_max,
    input  logic [63:0] s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    input  logic [63:0] s_peer_tdata,
    input  logic        s_peer_tvalid,
    output logic        s_peer_tready,
    input  logic [63:0] s_local_tdata,
    input  logic        s_local_tvalid,
    output logic        s_local_tready,
    output logic [63:0] m_tx_sfp_tdata,
    output logic        m_tx_sfp_tvalid,
    input  logic        m_tx_sfp_tready,
    output logic [1:0]  o_grant,
    output logic [1:0]  o_arb_state,
    output logic [31:0] o_beat_cnt
);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
    localparam logic [1:0] G_NONE = 2'd0, G_CMD = 2'd1, G_PEER = 2'd2, G_LOCAL = 2'd3;

    logic [1:0]  state_q, state_d, grant_q, grant_d;
    logic [31:0] beat_cnt_q;
    logic [7:0]  burst_q, burst_d, burst_lim;
    logic [3:0]  gap_q, gap_d;
    logic        last_local_q, last_local_d;
    logic        in_send, gnt_valid, beat, burst_done, grant_end, link_ok;
    logic [63:0] gnt_data;

    assign in_send   = state_q == SEND;
    assign link_ok   = in_send && i_channel_up;
    assign gnt_valid = grant_q == G_CMD  ? s_cmd_tvalid  :
                       grant_q == G_PEER ? s_peer_tvalid :
                       grant_q == G_LOCAL ? s_local_tvalid : 1'b0;
    assign gnt_data  = grant_q == G_CMD  ? s_cmd_tdata  :
                       grant_q == G_PEER ? s_peer_tdata :
                       grant_q == G_LOCAL ? s_local_tdata : 64'd0;

    assign m_tx_sfp_tvalid = link_ok && gnt_valid;
    assign m_tx_sfp_tdata  = in_send ? gnt_data : 64'd0;
    assign s_cmd_tready    = link_ok && grant_q == G_CMD   && m_tx_sfp_tready;
    assign s_peer_tready   = link_ok && grant_q == G_PEER  && m_tx_sfp_tready;
    assign s_local_tready  = link_ok && grant_q == G_LOCAL && m_tx_sfp_tready;

    assign beat       = m_tx_sfp_tvalid && m_tx_sfp_tready;
    assign burst_lim  = i_burst_max == 8'd0 ? 8'd1 : i_burst_max;
    assign burst_done = burst_q + 8'd1 == burst_lim;
    // a stalled beat never ends the grant; only a completed beat or a dropped valid does
    assign grant_end  = !gnt_valid || (beat && (grant_q == G_CMD || burst_done || s_cmd_tvalid));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        burst_d      = burst_q;
        gap_d        = gap_q;
        last_local_d = last_local_q;
        if (!i_channel_up) begin
            state_d = IDLE;
            grant_d = G_NONE;
            burst_d = 8'd0;
            gap_d   = 4'd0;
        end else if (state_q == IDLE) begin
            if (s_cmd_tvalid || s_peer_tvalid || s_local_tvalid) begin
                state_d = SEND;
                grant_d = s_cmd_tvalid ? G_CMD :
                          (s_peer_tvalid && (!s_local_tvalid || last_local_q)) ? G_PEER : G_LOCAL;
            end
        end else if (state_q == SEND) begin
            burst_d = beat ? burst_q + 8'd1 : burst_q;
            if (grant_end) begin
                state_d      = GAP;
                grant_d      = G_NONE;
                burst_d      = 8'd0;
                gap_d        = 4'(GAP_CYC - 1);
                last_local_d = grant_q == G_CMD ? last_local_q : grant_q == G_LOCAL;
            end
        end else begin
            state_d = gap_q == 4'd0 ? IDLE : GAP;
            gap_d   = gap_q == 4'd0 ? 4'd0 : gap_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            grant_q      <= G_NONE;
            burst_q      <= 8'd0;
            gap_q        <= 4'd0;
            last_local_q <= 1'b1;
            beat_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            burst_q      <= burst_d;
            gap_q        <= gap_d;
            last_local_q <= last_local_d;
            beat_cnt_q   <= beat ? beat_cnt_q + 32'd1 : beat_cnt_q;
        end
    end

    assign o_grant     = grant_q;
    assign o_arb_state = state_q;
    assign o_beat_cnt  = beat_cnt_q;
endmodule
